// File: rtl/lake_stim_gen.sv
// Stimulus generator for Lake memory tiles: holds the tile in reset, then streams
// ramp/constant/LFSR/walking-one beats on NUM_CH lockstep channels until run_length is reached.
module lake_stim_gen #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    NUM_CH     = 2,
    parameter int                    CNT_WIDTH  = 32,
    parameter int                    HOLD_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 16'hB400
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en,
    input  logic                         flush,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [DATA_WIDTH-1:0]        seed,
    input  logic [DATA_WIDTH-1:0]        stride,
    input  logic [HOLD_WIDTH-1:0]        hold_cycles,
    input  logic [CNT_WIDTH-1:0]         run_length,
    input  logic [NUM_CH-1:0]            ready_in,
    output logic                         tile_rst_n,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            valid_out,
    output logic                         active,
    output logic                         done,
    output logic [CNT_WIDTH-1:0]         beat_count
);

    localparam int WIDX = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    w_load;
    logic                    w_accept;
    logic [CNT_WIDTH-1:0]    w_beatNext;

    logic [HOLD_WIDTH-1:0]   r_holdCnt;
    logic [1:0]              r_mode;
    logic [DATA_WIDTH-1:0]   r_seed;
    logic [DATA_WIDTH-1:0]   r_stride;
    logic [CNT_WIDTH-1:0]    r_runLen;
    logic [CNT_WIDTH-1:0]    r_beatCnt;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_lfsr;
    logic [WIDX-1:0]         r_walk;
    logic [DATA_WIDTH-1:0]   w_lfsrNext;

    assign w_accept   = (r_state == S_RUN) && (&ready_in);
    assign w_beatNext = (&r_beatCnt) ? r_beatCnt : r_beatCnt + 1'b1;
    assign w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
    assign beat_count = r_beatCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        tile_rst_n  = 1'b0;
        valid_out   = '0;
        active      = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_HOLD;
                    w_load      = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_holdCnt <= HOLD_WIDTH'(1)) w_nextState = S_RUN;
            end
            S_RUN: begin
                tile_rst_n = 1'b1;
                valid_out  = '1;
                active     = 1'b1;
                if (w_accept && (r_runLen != '0) && (w_beatNext == r_runLen)) w_nextState = S_DONE;
            end
            S_DONE: begin
                tile_rst_n = 1'b1;
                done       = 1'b1;
                if (start) begin
                    w_nextState = S_HOLD;
                    w_load      = 1'b1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        // Flush overrides every transition, including a simultaneous start.
        if (flush) begin
            w_nextState = S_IDLE;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdCnt <= '0;
            r_mode    <= '0;
            r_seed    <= '0;
            r_stride  <= '0;
            r_runLen  <= '0;
            r_beatCnt <= '0;
            r_acc     <= '0;
            r_lfsr    <= '0;
            r_walk    <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_holdCnt <= '0;
                r_beatCnt <= '0;
            end else if (w_load) begin
                r_holdCnt <= (hold_cycles == '0) ? HOLD_WIDTH'(1) : hold_cycles;
                r_mode    <= mode;
                r_seed    <= seed;
                r_stride  <= stride;
                r_runLen  <= run_length;
                r_beatCnt <= '0;
                r_acc     <= seed;
                r_lfsr    <= (seed == '0) ? DATA_WIDTH'(1) : seed;
                r_walk    <= '0;
            end else begin
                if ((r_state == S_HOLD) && (r_holdCnt > HOLD_WIDTH'(1))) r_holdCnt <= r_holdCnt - 1'b1;
                if (w_accept) begin
                    r_beatCnt <= w_beatNext;
                    r_acc     <= r_acc + r_stride;
                    r_lfsr    <= w_lfsrNext;
                    r_walk    <= (r_walk == WIDX'(DATA_WIDTH - 1)) ? '0 : r_walk + 1'b1;
                end
            end
        end
    end

    // Channel values derive from the shared generator state; IDLE shows zeros.
    always_comb begin
        int                    rot;
        int                    idx;
        logic [DATA_WIDTH-1:0] chan;
        data_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rot  = c % DATA_WIDTH;
            idx  = (int'(r_walk) + c) % DATA_WIDTH;
            chan = '0;
            case (r_mode)
                2'd0:    chan = r_acc + DATA_WIDTH'(c);
                2'd1:    chan = r_seed;
                2'd2:    chan = (r_lfsr << rot) | (r_lfsr >> (DATA_WIDTH - rot));
                default: chan = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << idx;
            endcase
            if (r_state != S_IDLE) data_out[c*DATA_WIDTH +: DATA_WIDTH] = chan;
        end
    end

endmodule

// File: tb/tb_lake_stim_gen.sv
// Directed self-checking bench for lake_stim_gen (default parameters: 2 x 16-bit channels).
module tb_lake_stim_gen;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic [15:0] stride;
    logic [7:0]  hold_cycles;
    logic [31:0] run_length;
    logic [1:0]  ready_in;
    logic        tile_rst_n;
    logic [31:0] data_out;
    logic [1:0]  valid_out;
    logic        active;
    logic        done;
    logic [31:0] beat_count;

    int checks = 0;
    int errors = 0;

    lake_stim_gen dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .start(start),
        .mode(mode), .seed(seed), .stride(stride), .hold_cycles(hold_cycles),
        .run_length(run_length), .ready_in(ready_in), .tile_rst_n(tile_rst_n),
        .data_out(data_out), .valid_out(valid_out), .active(active), .done(done),
        .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Loads a configuration and pulses start; returns one cycle later (first HOLD cycle).
    task automatic applyStimulus(input logic [1:0] m, input logic [15:0] s, input logic [15:0] st,
                                 input logic [7:0] h, input logic [31:0] rl, input logic [1:0] rdy);
        mode = m; seed = s; stride = st; hold_cycles = h; run_length = rl; ready_in = rdy;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] one;
        one = 16'h0001;
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; start = 1'b0;
        mode = '0; seed = '0; stride = '0; hold_cycles = '0; run_length = '0; ready_in = '0;
        repeat (3) step();
        checkOutput("rst_tile", tile_rst_n, 0);
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_data", data_out, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_beats", beat_count, 0);
        rst_n = 1'b1;
        step();

        // Ramp, seed 0, stride 1, five beats
        applyStimulus(2'd0, 16'h0000, 16'h0001, 8'd2, 32'd5, 2'b11);
        checkOutput("hold1_tile", tile_rst_n, 0);
        step();
        checkOutput("hold2_tile", tile_rst_n, 0);
        checkOutput("hold2_active", active, 0);
        step();
        checkOutput("run_tile", tile_rst_n, 1);
        checkOutput("run_valid", valid_out, 2'b11);
        for (int n = 0; n < 5; n++) begin
            checkOutput("ramp_ch0", data_out[15:0], n);
            checkOutput("ramp_ch1", data_out[31:16], n + 1);
            step();
        end
        checkOutput("ramp_done", done, 1);
        checkOutput("ramp_beats", beat_count, 5);
        checkOutput("ramp_done_valid", valid_out, 0);
        checkOutput("ramp_done_active", active, 0);

        // Restart from DONE with one channel stalled for three RUN cycles
        applyStimulus(2'd0, 16'h0000, 16'h0001, 8'd2, 32'd5, 2'b01);
        checkOutput("restart_done_clr", done, 0);
        checkOutput("restart_beats_clr", beat_count, 0);
        step(); step();
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_ch0", data_out[15:0], 0);
            checkOutput("stall_ch1", data_out[31:16], 1);
            checkOutput("stall_beats", beat_count, 0);
            checkOutput("stall_valid", valid_out, 2'b11);
            step();
        end
        ready_in = 2'b11;
        for (int n = 0; n < 3; n++) begin
            checkOutput("resume_ch0", data_out[15:0], n);
            step();
        end

        // Freeze with clk_en low; the flush raised meanwhile must be ignored
        clk_en = 1'b0;
        flush  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("freeze_ch0", data_out[15:0], 3);
            checkOutput("freeze_beats", beat_count, 3);
            checkOutput("freeze_active", active, 1);
        end
        clk_en = 1'b1;
        start  = 1'b1;
        step();
        flush = 1'b0; start = 1'b0;
        checkOutput("flush_valid", valid_out, 0);
        checkOutput("flush_tile", tile_rst_n, 0);
        checkOutput("flush_beats", beat_count, 0);
        checkOutput("flush_data", data_out, 0);
        step();
        checkOutput("flush_stay_idle", tile_rst_n, 0);

        // LFSR with seed 0 and hold_cycles 0 (single HOLD cycle)
        applyStimulus(2'd2, 16'h0000, 16'h0000, 8'd0, 32'd0, 2'b11);
        checkOutput("h0_hold_tile", tile_rst_n, 0);
        step();
        checkOutput("h0_run_active", active, 1);
        checkOutput("lfsr0_ch0", data_out[15:0], 16'h0001);
        checkOutput("lfsr0_ch1", data_out[31:16], 16'h0002);
        step();
        checkOutput("lfsr1_ch0", data_out[15:0], 16'hB400);
        checkOutput("lfsr1_ch1", data_out[31:16], 16'h6801);
        step();
        checkOutput("lfsr2_ch0", data_out[15:0], 16'h5A00);
        checkOutput("lfsr2_ch1", data_out[31:16], 16'hB400);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Constant mode, two beats
        applyStimulus(2'd1, 16'hA5A5, 16'h0003, 8'd1, 32'd2, 2'b11);
        step();
        checkOutput("const_ch0", data_out[15:0], 16'hA5A5);
        checkOutput("const_ch1", data_out[31:16], 16'hA5A5);
        step(); step();
        checkOutput("const_done", done, 1);
        checkOutput("const_beats", beat_count, 2);

        // Walking one from DONE, wrapping past bit 15
        applyStimulus(2'd3, 16'h1234, 16'h0000, 8'd1, 32'd0, 2'b11);
        step();
        for (int n = 0; n < 18; n++) begin
            checkOutput("walk_ch0", data_out[15:0], one << (n % 16));
            checkOutput("walk_ch1", data_out[31:16], one << ((n + 1) % 16));
            step();
        end

        // Asynchronous reset between edges mid-run
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_tile", tile_rst_n, 0);
        checkOutput("arst_valid", valid_out, 0);
        checkOutput("arst_active", active, 0);
        checkOutput("arst_beats", beat_count, 0);
        checkOutput("arst_data", data_out, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lake_stim_gen.md
Name: lake_stim_gen

Overview:
- Synthesizable, parametrised stimulus generator for Lake memory-tile power and regression runs.
- Sequences a tile reset-hold, then drives NUM_CH data channels with ramp, constant, LFSR or walking-one patterns under a valid/ready handshake.
- Flags the measurement window on `active` and asserts `done` after a programmed beat count.
- Sits between the test harness or top-level controller and LakeWrapper data inputs; replaces open-coded ramp drivers.

Parameters:
- DATA_WIDTH, 16, width of each data channel.
- NUM_CH, 2, number of data channels.
- CNT_WIDTH, 32, width of beat counter and run_length.
- HOLD_WIDTH, 8, width of hold_cycles.
- LFSR_TAPS, 16'hB400, Galois LFSR feedback mask (DATA_WIDTH bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global enable; 0 freezes all state.
- flush  in  1  synchronous return to IDLE.
- start  in  1  begin sequence (sampled in IDLE/DONE).
- mode  in  2  0 ramp, 1 constant, 2 LFSR, 3 walking-one.
- seed  in  DATA_WIDTH  initial value.
- stride  in  DATA_WIDTH  ramp increment.
- hold_cycles  in  HOLD_WIDTH  tile reset hold length.
- run_length  in  CNT_WIDTH  beats to issue; 0 = unbounded.
- ready_in  in  NUM_CH  per-channel consumer ready.
- tile_rst_n  out  1  reset to downstream tile.
- data_out  out  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  NUM_CH  per-channel valid.
- active  out  1  measurement window (high in RUN).
- done  out  1  run complete.
- beat_count  out  CNT_WIDTH  accepted beats.

Behaviour:
- Reset (rst_n low, async):
  - state IDLE; tile_rst_n=0, data_out=0, valid_out=0, active=0, done=0, beat_count=0.
  - Reset mid-run aborts immediately.
- clk_en=0: no register updates, outputs hold. Flush is also ignored.
- States IDLE, HOLD, RUN, DONE:
  - IDLE: tile_rst_n=0. start=1 -> HOLD. Latch mode, seed, stride, run_length. Load hold counter with max(hold_cycles,1).
  - HOLD: tile_rst_n=0, decrement counter; counter==1 -> RUN next cycle. HOLD therefore lasts max(hold_cycles,1) cycles.
  - RUN: tile_rst_n=1, active=1, valid_out=all ones. Inputs changing mid-run have no effect (latched copies used).
  - DONE: tile_rst_n=1, valid_out=0, active=0, done=1. start=1 -> HOLD (restart; done clears on entering HOLD, beat_count clears, generator reseeds).
- Handshake (lockstep):
  - A beat is accepted when state==RUN and &ready_in==1.
  - On acceptance the generator advances and beat_count increments; otherwise data_out holds.
  - Valid never drops mid-RUN.
- Termination:
  - run_length!=0 and acceptance makes beat_count==run_length -> DONE next cycle.
  - run_length==0: runs until flush or reset.
  - beat_count saturates at all ones.
- Generator value n = accepted beats so far; all arithmetic mod 2^DATA_WIDTH:
  - ramp: ch c = seed + c + n*stride.
  - constant: all channels = seed.
  - LFSR: state starts at seed (seed==0 forced to 1); each advance: lsb=s[0]; s=s>>1; if lsb, s^=LFSR_TAPS. Ch c = state rotated left by c.
  - walking-one: ch c = 1 << ((n+c) mod DATA_WIDTH).
- data_out is valid first cycle of RUN with n=0 values.
- Edge cases:
  - flush (sync) in any state -> IDLE with reset output values. Flush and start in same cycle: flush wins.
  - start in HOLD/RUN is ignored.

Test Plan:
- Reset 3 cycles, hold_cycles=2, mode=0, seed=0, stride=1, run_length=5, ready=2'b11, start pulse:
  - tile_rst_n low 2 cycles after start.
  - Then ch0 = 0,1,2,3,4 and ch1 = 1,2,3,4,5 on consecutive cycles.
  - done=1 the cycle after the fifth beat; beat_count=5.
- Same config, ready_in=2'b01 for 3 RUN cycles: data_out holds at n=0 values, beat_count stays 0 during the stall, then resumes 0,1,2.
- mode=2, seed=0, NUM_CH=2, DATA_WIDTH=16: first ch0=0x0001, ch1=0x0002; next ch0=0xB400, ch1=0x6801.
- mode=3, seed ignored, DATA_WIDTH=16: ch0 = 1<<n wraps to 0x0001 at n=16; ch1 leads by one bit.
- Flush asserted with start in same cycle during RUN: next cycle IDLE, valid_out=0, tile_rst_n=0, beat_count=0. clk_en=0 for 4 cycles mid-RUN: all outputs frozen.
- Deassert rst_n asynchronously mid-RUN (between edges): outputs go to reset values immediately. hold_cycles=0 gives a 1-cycle HOLD.
